// File: rtl/sar_fe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_fe_pkg
// Description : Shared definitions for the SAR front-end emulator: FSM state
//               encoding, default code width / comparator latency, and the
//               noise LFSR seed and tap mask.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_fe_pkg;

    localparam int c_default_width   = 4;
    localparam int c_default_cmp_lat = 1;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bit positions 7,5,4,3
    localparam logic [7:0] c_lfsr_seed = 8'hA5;
    localparam logic [7:0] c_lfsr_taps = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sar_fe_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sar_fe_cmp_pipe
// Description : Comparator latency line. Delays the raw compare bit by exactly
//               CMP_LAT clock cycles; a synchronous flush zeroes every stage.
// Ports       : clk   - clock
//               reset - asynchronous active-high reset
//               flush - clears all stages on the next rising edge
//               din   - raw compare bit
//               dout  - compare bit delayed by CMP_LAT cycles
// Revision    : 1.0 - initial release
// ============================================================================
module sar_fe_cmp_pipe #(
    parameter int CMP_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [CMP_LAT-1:0] r_pipe;

    generate
        if (CMP_LAT == 1) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pipe <= '0;
                end else if (flush) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pipe <= '0;
                end else if (flush) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[CMP_LAT-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = r_pipe[CMP_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sar_frontend_emu.sv
`default_nettype none
// ============================================================================
// Module      : sar_frontend_emu
// Description : Digital emulation of a SAR ADC analog front end: sample-and-
//               hold of vin, a latency-modelled comparator feeding the SAR,
//               and a final-code check with sticky error and a saturating
//               conversion counter.
// Ports       : clk        - clock, all state changes on rising edge
//               reset      - asynchronous active-high reset
//               vin        - digital stand-in for the analog input
//               sample     - one-cycle sample-and-hold request
//               dac_code   - SAR trial code
//               conv_done  - SAR end-of-conversion strobe
//               d          - comparator decision (1 = held >= dac_code)
//               held       - currently held sample
//               busy       - high while HOLD or CHECK
//               result_ok  - one-cycle pulse on accepted final code
//               err        - sticky flag on rejected final code
//               conv_count - completed conversions, saturating at 255
// Config      : SAR_FE_NOISE_EN - when defined, an LFSR dithers the compare
//               threshold by +1 and CHECK accepts codes within +/-1 of held.
//               CMP_LAT is legal in the range 1..3.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_frontend_emu
    import sar_fe_pkg::*;
#(
    parameter int WIDTH   = c_default_width,
    parameter int CMP_LAT = c_default_cmp_lat
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] vin,
    input  logic             sample,
    input  logic [WIDTH-1:0] dac_code,
    input  logic             conv_done,
    output logic             d,
    output logic [WIDTH-1:0] held,
    output logic             busy,
    output logic             result_ok,
    output logic             err,
    output logic [7:0]       conv_count
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_busy;
    logic [WIDTH-1:0] r_held;
    logic             r_result_ok;
    logic             r_err;
    logic [7:0]       r_conv_count;

    logic [WIDTH-1:0] w_threshold;
    logic             w_accept;
    logic             w_cmp_raw;
    logic             w_flush;
    logic             w_pipe_out;

`ifdef SAR_FE_NOISE_EN
    logic [7:0]       r_lfsr;
    logic [WIDTH-1:0] w_diff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= c_lfsr_seed;
        end else if (r_state == ST_HOLD) begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & c_lfsr_taps)};
        end
    end

    always_comb begin
        w_threshold = r_held;
        // Dither up by one, but never wrap past all-ones
        if (r_lfsr[0] && (r_held != '1)) begin
            w_threshold = r_held + WIDTH'(1);
        end
        w_diff   = (dac_code >= r_held) ? (dac_code - r_held) : (r_held - dac_code);
        w_accept = (w_diff <= WIDTH'(1));
    end
`else
    always_comb begin
        w_threshold = r_held;
        w_accept    = (dac_code == r_held);
    end
`endif

    assign w_cmp_raw = (w_threshold >= dac_code);
    assign w_flush   = (r_state == ST_IDLE);

    sar_fe_cmp_pipe #(
        .CMP_LAT (CMP_LAT)
    ) u_cmp_pipe (
        .clk   (clk),
        .reset (reset),
        .flush (w_flush),
        .din   (w_cmp_raw),
        .dout  (w_pipe_out)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; conv_done has priority over sample because sample is
    // simply not looked at outside IDLE.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sample) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_busy = 1'b1;
                if (conv_done) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_busy       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Sample-and-hold, final-code check and conversion bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held       <= '0;
            r_result_ok  <= 1'b0;
            r_err        <= 1'b0;
            r_conv_count <= 8'd0;
        end else begin
            r_result_ok <= 1'b0;
            if ((r_state == ST_IDLE) && sample) begin
                r_held <= vin;
            end
            if (r_state == ST_CHECK) begin
                r_result_ok <= w_accept;
                if (!w_accept) begin
                    r_err <= 1'b1;
                end
                if (r_conv_count != 8'hFF) begin
                    r_conv_count <= r_conv_count + 8'd1;
                end
            end
        end
    end

    // The pipeline is only flushed on the edge that leaves IDLE-time, so the
    // first IDLE cycle after CHECK can still hold stale stages; mask them.
    assign d          = (r_state == ST_IDLE) ? 1'b0 : w_pipe_out;
    assign held       = r_held;
    assign busy       = w_busy;
    assign result_ok  = r_result_ok;
    assign err        = r_err;
    assign conv_count = r_conv_count;

endmodule
`default_nettype wire

// File: tb/tb_sar_frontend_emu.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_frontend_emu
// Description : Self-checking bench for sar_frontend_emu. Two instances
//               (CMP_LAT=1 and CMP_LAT=3) share one stimulus stream and are
//               compared every cycle against a timeline-based reference model,
//               plus directed checks on the documented scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_frontend_emu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample = 1'b0;
    logic       conv_done = 1'b0;
    logic [3:0] vin = 4'd0;
    logic [3:0] dac_code = 4'd0;

    logic       d1, busy1, ok1, err1;
    logic [3:0] held1;
    logic [7:0] cnt1;
    logic       d3, busy3, ok3, err3;
    logic [3:0] held3;
    logic [7:0] cnt3;

    always #5 clk = ~clk;

    sar_frontend_emu #(.WIDTH(4), .CMP_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .vin(vin), .sample(sample),
        .dac_code(dac_code), .conv_done(conv_done), .d(d1), .held(held1),
        .busy(busy1), .result_ok(ok1), .err(err1), .conv_count(cnt1)
    );

    sar_frontend_emu #(.WIDTH(4), .CMP_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .vin(vin), .sample(sample),
        .dac_code(dac_code), .conv_done(conv_done), .d(d3), .held(held3),
        .busy(busy3), .result_ok(ok3), .err(err3), .conv_count(cnt3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 = waiting for sample, 1 = converting, 2 = final-code check.
    int         m_phase;
    logic [3:0] m_held;
    bit         m_ok, m_err;
    int         m_cnt;
    bit [7:0]   m_lfsr;
    int         m_edge = 0;
    int         m_flush_edge = 0;
    bit         m_capt[int];   // compare value captured at each edge

    function automatic bit m_d(input int lat);
        int src;
        src = m_edge - lat + 1;
        if (m_phase == 0) return 1'b0;
        if (src <= m_flush_edge) return 1'b0;
        return m_capt[src];
    endfunction

    task automatic model_reset();
        m_phase = 0; m_held = 4'd0; m_ok = 0; m_err = 0; m_cnt = 0;
        m_lfsr = 8'hA5; m_flush_edge = m_edge;
    endtask

    task automatic model_edge();
        int thr;
        bit cmp, acc;
        int diff;
        if (reset) return;
        m_edge++;
        thr = m_held;
`ifdef SAR_FE_NOISE_EN
        if (m_lfsr[0] && thr < 15) thr = thr + 1;
`endif
        cmp = (thr >= int'(dac_code));
        if (m_phase == 0) begin
            m_capt[m_edge] = 1'b0;
            m_flush_edge   = m_edge;
        end else begin
            m_capt[m_edge] = cmp;
        end
        m_ok = 0;
        case (m_phase)
            0: if (sample) begin m_held = vin; m_phase = 1; end
            1: begin
`ifdef SAR_FE_NOISE_EN
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
                if (conv_done) m_phase = 2;
            end
            default: begin
                diff = int'(dac_code) - int'(m_held);
                if (diff < 0) diff = -diff;
`ifdef SAR_FE_NOISE_EN
                acc = (diff <= 1);
`else
                acc = (diff == 0);
`endif
                m_ok = acc;
                if (!acc) m_err = 1;
                if (m_cnt < 255) m_cnt++;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".d1"},    32'(d1),    32'(m_d(1)));
        check({tag, ".d3"},    32'(d3),    32'(m_d(3)));
        check({tag, ".held1"}, 32'(held1), 32'(m_held));
        check({tag, ".held3"}, 32'(held3), 32'(m_held));
        check({tag, ".busy1"}, 32'(busy1), 32'(m_phase != 0));
        check({tag, ".busy3"}, 32'(busy3), 32'(m_phase != 0));
        check({tag, ".ok1"},   32'(ok1),   32'(m_ok));
        check({tag, ".ok3"},   32'(ok3),   32'(m_ok));
        check({tag, ".err1"},  32'(err1),  32'(m_err));
        check({tag, ".err3"},  32'(err3),  32'(m_err));
        check({tag, ".cnt1"},  32'(cnt1),  32'(m_cnt));
        check({tag, ".cnt3"},  32'(cnt3),  32'(m_cnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample = 1'b0; conv_done = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    // Sample v, run some random trial codes, then finish with final_code.
    task automatic convert(input logic [3:0] v, input logic [3:0] final_code, input int trials);
        vin = v; sample = 1'b1; cycle(); sample = 1'b0;
        for (int t = 0; t < trials; t++) begin
            dac_code = 4'($urandom_range(15));
            cycle();
        end
        dac_code = final_code; conv_done = 1'b1; cycle();
        conv_done = 1'b0; cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        check("reset.cnt", 32'(cnt1), 32'd0);
        check("reset.busy", 32'(busy1), 32'd0);

        // Exact conversion of 0xB with binary search 8,C,A,B
        vin = 4'hB; sample = 1'b1; cycle(); sample = 1'b0;
        dac_code = 4'h8; cycle(); check("exact.d8", 32'(d1), 32'd1);
        dac_code = 4'hC; cycle(); check("exact.dC", 32'(d1), 32'd0);
        dac_code = 4'hA; cycle(); check("exact.dA", 32'(d1), 32'd1);
        dac_code = 4'hB; conv_done = 1'b1; cycle(); check("exact.dB", 32'(d1), 32'd1);
        conv_done = 1'b0; cycle();
        check("exact.ok", 32'(ok1), 32'd1);
        check("exact.cnt", 32'(cnt1), 32'd1);
        cycle(); check("exact.ok_pulse", 32'(ok1), 32'd0);

        // Latency 3: held=5, dac steps 4 -> 6
        vin = 4'd5; sample = 1'b1; cycle(); sample = 1'b0;
        dac_code = 4'd4; repeat (3) cycle();
        check("lat.pre", 32'(d3), 32'd1);
        dac_code = 4'd6;
        cycle(); check("lat.c1", 32'(d3), 32'd1);
        cycle(); check("lat.c2", 32'(d3), 32'd1);
        cycle(); check("lat.c3", 32'(d3), 32'd0);
        dac_code = 4'd5; conv_done = 1'b1; cycle(); conv_done = 1'b0; cycle();
        check("lat.ok", 32'(ok3), 32'd1);

        // Bad result, then three good ones; err stays sticky
        do_reset();
        convert(4'd7, 4'd6, 2);
        check("bad.err", 32'(err1), 32'd1);
        check("bad.ok", 32'(ok1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(15));
            convert(v, v, 2);
        end
        check("bad.err_sticky", 32'(err1), 32'd1);
        check("bad.cnt", 32'(cnt1), 32'd4);

        // Boundaries
        vin = 4'd0; sample = 1'b1; cycle(); sample = 1'b0;
        dac_code = 4'd0; cycle(); check("bnd.zero", 32'(d1), 32'd1);
        conv_done = 1'b1; cycle(); conv_done = 1'b0; cycle();
        vin = 4'hF; sample = 1'b1; cycle(); sample = 1'b0;
        dac_code = 4'hF; cycle(); check("bnd.full", 32'(d1), 32'd1);
        conv_done = 1'b1; cycle(); conv_done = 1'b0; cycle();
        check("bnd.cnt6", 32'(cnt1), 32'd6);
        conv_done = 1'b1; cycle(); cycle(); conv_done = 1'b0;
        check("bnd.idle_done_cnt", 32'(cnt1), 32'd6);
        check("bnd.idle_done_busy", 32'(busy1), 32'd0);
        vin = 4'd3; sample = 1'b1; cycle();
        vin = 4'd9; dac_code = 4'd3; conv_done = 1'b1; cycle();
        sample = 1'b0; conv_done = 1'b0;
        check("bnd.check_busy", 32'(busy1), 32'd1);
        check("bnd.check_held", 32'(held1), 32'd3);
        cycle();
        check("bnd.check_ok", 32'(ok1), 32'd1);
        check("bnd.check_cnt", 32'(cnt1), 32'd7);

        // Randomized conversions with ignored sample/conv_done noise
        for (int i = 0; i < 40; i++) begin
            logic [3:0] v, fc;
            int trials;
            v = 4'($urandom_range(15));
            fc = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : v;
            trials = $urandom_range(5);
            conv_done = 1'($urandom_range(1));
            cycle();
            conv_done = 1'b0;
            vin = v; sample = 1'b1; cycle(); sample = 1'b0;
            for (int t = 0; t < trials; t++) begin
                dac_code = 4'($urandom_range(15));
                sample = 1'($urandom_range(1));
                vin = 4'($urandom_range(15));
                cycle();
            end
            sample = 1'b0;
            dac_code = fc; conv_done = 1'b1; cycle();
            conv_done = 1'b0; cycle();
        end

        // Saturation, then reset mid-HOLD
        do_reset();
        for (int i = 0; i < 260; i++) begin
            vin = 4'($urandom_range(15)); sample = 1'b1; cycle();
            sample = 1'b0; dac_code = vin; conv_done = 1'b1; cycle();
            conv_done = 1'b0; cycle();
        end
        check("sat.cnt", 32'(cnt1), 32'd255);
        check("sat.cnt3", 32'(cnt3), 32'd255);
        vin = 4'd12; sample = 1'b1; cycle(); sample = 1'b0; dac_code = 4'd2; cycle();
        check("abort.busy_pre", 32'(busy1), 32'd1);
        reset = 1'b1; #1; model_reset();
        check("abort.d", 32'(d1), 32'd0);
        check("abort.held", 32'(held1), 32'd0);
        check("abort.busy", 32'(busy1), 32'd0);
        check("abort.ok", 32'(ok1), 32'd0);
        check("abort.err", 32'(err1), 32'd0);
        check("abort.cnt", 32'(cnt1), 32'd0);
        cycle();
        reset = 1'b0;
        vin = 4'd6; sample = 1'b1; cycle(); sample = 1'b0;
        check("post_rst.busy", 32'(busy1), 32'd1);
        check("post_rst.held", 32'(held1), 32'd6);
        dac_code = 4'd6; conv_done = 1'b1; cycle(); conv_done = 1'b0; cycle();
        check("post_rst.cnt", 32'(cnt1), 32'd1);

        // Final-code tolerance: held=9, results 10 and 11
        do_reset();
        convert(4'd9, 4'd10, 3);
`ifdef SAR_FE_NOISE_EN
        check("noise.ok10", 32'(ok1), 32'd1);
        check("noise.err10", 32'(err1), 32'd0);
`else
        check("exact.ok10", 32'(ok1), 32'd0);
        check("exact.err10", 32'(err1), 32'd1);
`endif
        convert(4'd9, 4'd11, 3);
        check("tol.err11", 32'(err1), 32'd1);
        check("tol.ok11", 32'(ok1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sar_frontend_emu.md
SAR_FRONTEND_EMU -- requirements
Module: sar_frontend_emu

Interface
REQ-001 Parameter: WIDTH, 4, code width of held sample and DAC trial code.
REQ-002 Parameter: CMP_LAT, 1, comparator latency in cycles, legal range 1..3.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 vin  input  WIDTH  digital stand-in for analog input voltage.
REQ-006 sample  input  1  one-cycle pulse requesting sample-and-hold of vin.
REQ-007 dac_code  input  WIDTH  SAR trial code (driven from the SAR bitout).
REQ-008 conv_done  input  1  SAR end-of-conversion strobe.
REQ-009 d  output  1  comparator decision to the SAR; 1 = held >= dac_code.
REQ-010 held  output  WIDTH  currently held sample.
REQ-011 busy  output  1  high in HOLD and CHECK states.
REQ-012 result_ok  output  1  one-cycle pulse when the final SAR code is accepted.
REQ-013 err  output  1  sticky flag set when a final SAR code is rejected.
REQ-014 conv_count  output  8  number of completed conversions, saturating.

Function
REQ-015 FSM states SHALL be IDLE, HOLD and CHECK.
REQ-016 IDLE: sample=1 SHALL latch vin into held and enter HOLD on the next edge.
REQ-017 HOLD: raw compare SHALL be (held >= dac_code), evaluated as unsigned WIDTH-bit every cycle.
REQ-018 d SHALL equal raw compare delayed by exactly CMP_LAT cycles through a register pipeline.
REQ-019 In IDLE, d SHALL be forced 0 and the pipeline SHALL be flushed to 0.
REQ-020 HOLD + conv_done=1 SHALL enter CHECK; sample in HOLD or CHECK SHALL be ignored; held SHALL be unchanged.
REQ-021 HOLD with conv_done=1 and sample=1 in the same cycle SHALL act on conv_done only.
REQ-022 CHECK (one cycle) SHALL accept when dac_code == held: pulse result_ok; otherwise set err.
REQ-023 CHECK SHALL increment conv_count, saturating at 255 with no wrap, then return to IDLE.
REQ-024 conv_done in IDLE SHALL be ignored: no count, no flag.
REQ-025 err SHALL clear only on reset.

Reset
REQ-026 Reset SHALL force IDLE with held=0, d=0, pipeline=0, busy=0, result_ok=0, err=0, conv_count=0.
REQ-027 Reset asserted mid-HOLD or mid-CHECK SHALL abort the conversion with no count increment.
REQ-028 After reset deassertion, the first sample SHALL be accepted on the first rising edge.

Configuration
REQ-029 Macro SAR_FE_NOISE_EN SHALL control comparator-noise injection.
REQ-030 With the macro defined:
- an 8-bit Fibonacci LFSR SHALL run, with taps 8,6,5,4 and seed 8'hA5 on reset, stepping every HOLD cycle.
- The compare threshold SHALL be held+1 when lfsr[0]=1, with the sum saturating at all-ones.
- CHECK SHALL accept |dac_code - held| <= 1.
REQ-031 Without the macro, no LFSR SHALL exist, the compare SHALL be exact, and CHECK SHALL require exact equality.

Structure
REQ-032 Package sar_fe_pkg SHALL hold:
- the FSM state enum
- the default WIDTH and CMP_LAT values
- the LFSR seed and tap constants
REQ-033 The latency pipeline SHALL be a sub-module sar_fe_cmp_pipe with parameter CMP_LAT and ports clk, reset, flush, din, dout.

Verification
REQ-034 Exact convert (WIDTH=4, CMP_LAT=1, no macro):
- Stimulus: vin=4'hB with a sample pulse; drive the SAR binary search 8,C,A,B.
- Response: d sequence 1,0,1,1; after conv_done with dac_code=B, result_ok pulses once and conv_count=1.
REQ-035 Latency (CMP_LAT=3):
- Stimulus: held=5; step dac_code from 4 to 6.
- Response: d goes 1->0 exactly 3 cycles after the step.
REQ-036 Bad result:
- Stimulus: held=7; conv_done with dac_code=6.
- Response: err=1 and remains 1 across 3 further good conversions; conv_count=4.
REQ-037 Boundaries:
- Stimulus: vin=0 and vin=F; conv_done in IDLE; sample and conv_done together in HOLD.
- Response: d=1 at dac_code=0 when held=0; d=1 at dac_code=F when held=F; no count from conv_done in IDLE; CHECK entered with held unchanged.
REQ-038 Saturation and reset:
- Stimulus: 260 conversions, then reset asserted mid-HOLD.
- Response: conv_count holds at 255; after reset all outputs are 0, with no increment from the aborted conversion.
REQ-039 Noise (SAR_FE_NOISE_EN defined):
- Stimulus: held=9; SAR result 10.
- Response: result_ok pulses and err=0.
- Stimulus: SAR result 11.
- Response: err=1.
